afns_link_ctrl: RTL and testbench

- Sequences the CAC/local-AFNS TSV link: owns the fault-flag vector that drives the sender-side and receiver-side FNS adders.
- Gates upstream data into the coder through a valid/ready handshake.
- Reconfiguration on a fault-map change: holds traffic, applies new flags, waits for the adders to settle, then resumes, or declares the link failed.

---
 rtl/afns_pkg.sv | 23 ++
 rtl/afns_link_ctrl_if.sv | 30 +++
 rtl/afns_settle_timer.sv | 32 +++
 rtl/afns_link_ctrl.sv | 144 ++++++++++++++
 tb/tb_afns_link_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/afns_pkg.sv
// rtl/afns_pkg.sv - shared types, defaults and helpers for the AFNS TSV link controllers
package afns_pkg;

   localparam int NTSV_DEF = 4;
   localparam int DW_DEF   = 7;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_SETTLE = 2'd2,
      ST_FAIL   = 2'd3
   } link_state_e;

   function automatic int unsigned popcount(input logic [NTSV_DEF-1:0] mask);
      int unsigned n;
      n = 0;
      for (int i = 0; i < NTSV_DEF; i++) begin
         n = n + 32'(mask[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/afns_link_ctrl_if.sv
// rtl/afns_link_ctrl_if.sv - fault-map, upstream handshake and coder-side bundle of the link controller
interface afns_link_ctrl_if import afns_pkg::*; #(
   parameter int NTSV = NTSV_DEF,
   parameter int DW   = DW_DEF
) ();

   logic [NTSV-1:0] fault_in;
   logic            fault_upd;
   logic            clear_faults;
   logic            in_valid;
   logic [DW-1:0]   in_data;
   logic            in_ready;
   logic [DW-1:0]   coder_data;
   logic            coder_load;
   logic [NTSV-1:0] f_flag;
   logic            link_busy;
   logic            link_fail;
   logic [7:0]      reconf_cnt;

   modport master (
      output fault_in, fault_upd, clear_faults, in_valid, in_data,
      input  in_ready, coder_data, coder_load, f_flag, link_busy, link_fail, reconf_cnt
   );

   modport slave (
      input  fault_in, fault_upd, clear_faults, in_valid, in_data,
      output in_ready, coder_data, coder_load, f_flag, link_busy, link_fail, reconf_cnt
   );

endinterface

// File: rtl/afns_settle_timer.sv
// rtl/afns_settle_timer.sv - 4-bit loadable down-counter; done while the count is zero
module afns_settle_timer (
   input  logic       clock,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic       done
);

   logic [3:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != 4'd0)) begin
         count_d = count_q - 4'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= 4'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done = (count_q == 4'd0);

endmodule

// File: rtl/afns_link_ctrl.sv
// rtl/afns_link_ctrl.sv - CAC/local-AFNS TSV link sequencer: fault flags, traffic gating, reconfiguration
module afns_link_ctrl import afns_pkg::*; #(
   parameter int NTSV       = NTSV_DEF,
   parameter int DW         = DW_DEF,
   parameter int SETTLE_CYC = 2,
   parameter int MAX_FAULTS = 2
) (
   input  logic             clock,
   input  logic             reset,
   afns_link_ctrl_if.slave  bus
);

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

   link_state_e     state_q, state_d;
   logic [NTSV-1:0] f_flag_q, f_flag_d;
   logic [NTSV-1:0] pend_q, pend_d;
   logic [DW-1:0]   coder_data_q, coder_data_d;
   logic            coder_load_q, coder_load_d;
   logic            link_busy_q, link_busy_d;
   logic            link_fail_q, link_fail_d;
   logic [7:0]      reconf_cnt_q, reconf_cnt_d;

   logic [NTSV-1:0] new_bits;
   logic            upd_new;
   logic            in_ready;
   logic            xfer;
   logic            tmr_load;
   logic            tmr_dec;
   logic            tmr_done;

   // pend always holds every fault seen so far, so comparing against it catches
   // bits that arrive while a previous update is still being applied.
   assign new_bits = bus.fault_in & ~pend_q;
   assign upd_new  = bus.fault_upd && (new_bits != '0);
   assign in_ready = !reset && (state_q == ST_RUN) && !upd_new;
   assign xfer     = bus.in_valid && in_ready;

   afns_settle_timer u_settle_timer (
      .clock    (clock),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (SETTLE_LOAD),
      .dec      (tmr_dec),
      .done     (tmr_done)
   );

   always_comb begin
      state_d      = state_q;
      f_flag_d     = f_flag_q;
      pend_d       = pend_q;
      coder_data_d = coder_data_q;
      coder_load_d = xfer;
      reconf_cnt_d = reconf_cnt_q;
      tmr_load     = 1'b0;
      tmr_dec      = 1'b0;

      if (xfer) begin
         coder_data_d = bus.in_data;
      end

      if (bus.clear_faults) begin
         f_flag_d = '0;
         pend_d   = '0;
         state_d  = ST_SETTLE;
         tmr_load = 1'b1;
      end else begin
         if (bus.fault_upd) begin
            pend_d = pend_q | bus.fault_in;
         end
         case (state_q)
            ST_RUN: begin
               if (upd_new) begin
                  state_d = ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               // A fresh update here keeps us in DRAIN so the merged map is applied once.
               if (!upd_new) begin
                  f_flag_d = pend_q;
                  if (int'(popcount(pend_q)) > MAX_FAULTS) begin
                     state_d = ST_FAIL;
                  end else begin
                     state_d  = ST_SETTLE;
                     tmr_load = 1'b1;
                  end
               end
            end
            ST_SETTLE: begin
               if (upd_new) begin
                  state_d = ST_DRAIN;
               end else if (tmr_done) begin
                  state_d = ST_RUN;
                  if (reconf_cnt_q != 8'hFF) begin
                     reconf_cnt_d = reconf_cnt_q + 8'd1;
                  end
               end else begin
                  tmr_dec = 1'b1;
               end
            end
            ST_FAIL: begin
               state_d = ST_FAIL;
            end
            default: begin
               state_d = ST_RUN;
            end
         endcase
      end

      link_busy_d = (state_d == ST_DRAIN) || (state_d == ST_SETTLE);
      link_fail_d = (state_d == ST_FAIL);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_RUN;
         f_flag_q     <= '0;
         pend_q       <= '0;
         coder_data_q <= '0;
         coder_load_q <= 1'b0;
         link_busy_q  <= 1'b0;
         link_fail_q  <= 1'b0;
         reconf_cnt_q <= 8'd0;
      end else begin
         state_q      <= state_d;
         f_flag_q     <= f_flag_d;
         pend_q       <= pend_d;
         coder_data_q <= coder_data_d;
         coder_load_q <= coder_load_d;
         link_busy_q  <= link_busy_d;
         link_fail_q  <= link_fail_d;
         reconf_cnt_q <= reconf_cnt_d;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.coder_data = coder_data_q;
   assign bus.coder_load = coder_load_q;
   assign bus.f_flag     = f_flag_q;
   assign bus.link_busy  = link_busy_q;
   assign bus.link_fail  = link_fail_q;
   assign bus.reconf_cnt = reconf_cnt_q;

endmodule

// File: tb/tb_afns_link_ctrl.sv
// tb/tb_afns_link_ctrl.sv - scoreboard bench for afns_link_ctrl against a behavioural link model
module tb_afns_link_ctrl;

   localparam int SETTLE_CYC = 2;
   localparam int MAX_FAULTS = 2;

   typedef struct {
      bit         rdy;
      bit         load;
      logic [6:0] data;
      logic [3:0] flags;
      bit         busy;
      bit         fail;
      logic [7:0] cnt;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   bit   mon_en;

   exp_t       st_q[$];
   logic [6:0] data_q[$];

   // Behavioural model: m_hold counts busy cycles still to come (SETTLE_CYC+1 = drain cycle).
   logic [3:0] m_acc;
   logic [3:0] m_flags;
   bit         m_fail;
   int         m_hold;
   int         m_cnt;
   logic [6:0] m_data;
   logic [6:0] src_word;

   afns_link_ctrl_if bus_if ();

   afns_link_ctrl #(
      .NTSV       (4),
      .DW         (7),
      .SETTLE_CYC (SETTLE_CYC),
      .MAX_FAULTS (MAX_FAULTS)
   ) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus_if.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_acc   = 4'd0;
      m_flags = 4'd0;
      m_fail  = 1'b0;
      m_hold  = 0;
      m_cnt   = 0;
      m_data  = 7'd0;
   endtask

   task automatic cyc(input bit fv, input logic [3:0] fi, input bit clr, input bit iv);
      exp_t       e;
      logic [3:0] nb;
      bit         rdy;
      @(negedge clk);
      bus_if.fault_upd    = fv;
      bus_if.fault_in     = fi;
      bus_if.clear_faults = clr;
      bus_if.in_valid     = iv;
      bus_if.in_data      = src_word;
      nb  = fv ? (fi & ~m_acc) : 4'd0;
      rdy = (m_hold == 0) && !m_fail && (nb == 4'd0);
      e.rdy  = rdy;
      e.load = iv && rdy;
      if (iv && rdy) begin
         data_q.push_back(src_word);
         m_data   = src_word;
         src_word = 7'($urandom_range(0, 99));
      end
      if (clr) begin
         m_acc   = 4'd0;
         m_flags = 4'd0;
         m_fail  = 1'b0;
         m_hold  = SETTLE_CYC;
      end else if (m_fail) begin
         if (fv) m_acc = m_acc | fi;
      end else if (nb != 4'd0) begin
         m_acc  = m_acc | nb;
         m_hold = SETTLE_CYC + 1;
      end else if (m_hold == SETTLE_CYC + 1) begin
         m_flags = m_acc;
         if ($countones(m_acc) > MAX_FAULTS) begin
            m_fail = 1'b1;
            m_hold = 0;
         end else begin
            m_hold = SETTLE_CYC;
         end
      end else if (m_hold > 0) begin
         m_hold--;
         if (m_hold == 0 && m_cnt < 255) m_cnt++;
      end
      e.data  = m_data;
      e.flags = m_flags;
      e.busy  = (m_hold > 0);
      e.fail  = m_fail;
      e.cnt   = 8'(m_cnt);
      st_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 1'b0, 1'b0);
   endtask

   task automatic stream(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 1'b0, 1'b1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"},   32'(bus_if.in_ready),   32'd0);
      chk({tag, "_coder_load"}, 32'(bus_if.coder_load), 32'd0);
      chk({tag, "_coder_data"}, 32'(bus_if.coder_data), 32'd0);
      chk({tag, "_f_flag"},     32'(bus_if.f_flag),     32'd0);
      chk({tag, "_link_busy"},  32'(bus_if.link_busy),  32'd0);
      chk({tag, "_link_fail"},  32'(bus_if.link_fail),  32'd0);
      chk({tag, "_reconf_cnt"}, 32'(bus_if.reconf_cnt), 32'd0);
   endtask

   // Monitor: pops one expectation per driven cycle; in_ready before the edge, registers after it.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (mon_en && st_q.size() > 0) begin
            e = st_q.pop_front();
            chk("in_ready", 32'(bus_if.in_ready), 32'(e.rdy));
            @(posedge clk);
            #1;
            chk("coder_load", 32'(bus_if.coder_load), 32'(e.load));
            if (bus_if.coder_load === 1'b1) begin
               if (data_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL coder_word act=%0h exp=none", bus_if.coder_data);
               end else begin
                  chk("coder_word", 32'(bus_if.coder_data), 32'(data_q.pop_front()));
               end
            end
            chk("coder_data", 32'(bus_if.coder_data), 32'(e.data));
            chk("f_flag",     32'(bus_if.f_flag),     32'(e.flags));
            chk("link_busy",  32'(bus_if.link_busy),  32'(e.busy));
            chk("link_fail",  32'(bus_if.link_fail),  32'(e.fail));
            chk("reconf_cnt", 32'(bus_if.reconf_cnt), 32'(e.cnt));
         end
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      mon_en = 1'b0;
      rst    = 1'b1;
      bus_if.fault_in     = 4'd0;
      bus_if.fault_upd    = 1'b0;
      bus_if.clear_faults = 1'b0;
      bus_if.in_valid     = 1'b0;
      bus_if.in_data      = 7'd0;
      src_word = 7'($urandom_range(0, 99));
      model_reset();

      #12;
      chk_reset_outputs("por");
      @(negedge clk);
      rst    = 1'b0;
      mon_en = 1'b1;

      stream(50);

      stream(5);
      cyc(1'b1, 4'b0010, 1'b0, 1'b1);
      stream(8);

      cyc(1'b1, 4'b0010, 1'b0, 1'b1);
      stream(3);

      cyc(1'b0, 4'd0, 1'b1, 1'b1);
      stream(3);
      cyc(1'b1, 4'b0001, 1'b0, 1'b1);
      cyc(1'b1, 4'b0100, 1'b0, 1'b1);
      stream(6);

      cyc(1'b0, 4'd0, 1'b1, 1'b0);
      idle(3);
      cyc(1'b1, 4'b1011, 1'b0, 1'b1);
      stream(4);
      cyc(1'b1, 4'b0100, 1'b0, 1'b1);
      cyc(1'b1, 4'b0100, 1'b1, 1'b1);
      stream(5);

      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)),
             ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0));
      end

      cyc(1'b0, 4'd0, 1'b1, 1'b0);
      idle(3);
      cyc(1'b1, 4'b0011, 1'b0, 1'b0);
      idle(1);
      @(posedge clk);
      #2;
      chk("pre_reset_f_flag", 32'(bus_if.f_flag),    32'h3);
      chk("pre_reset_busy",   32'(bus_if.link_busy), 32'h1);
      mon_en = 1'b0;
      rst    = 1'b1;
      #1;
      chk_reset_outputs("async");
      @(negedge clk);
      @(negedge clk);
      chk("scoreboard_at_reset", 32'(data_q.size()), 32'd0);
      st_q.delete();
      data_q.delete();
      rst = 1'b0;
      model_reset();
      mon_en = 1'b1;
      stream(10);

      @(posedge clk);
      #3;
      chk("words_left", 32'(data_q.size()), 32'd0);
      chk("cycles_left", 32'(st_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
